// File: rtl/parking_gate_ctrl.sv
// Car-park entrance gate controller: password check with retry lockout, occupancy
// tracking against CAPACITY, and fully registered indicator/actuator outputs.
module parking_gate_ctrl #(
  parameter int unsigned           PW_WIDTH    = 4,
  parameter logic [PW_WIDTH-1:0]   PASSWORD    = 4'hB,
  parameter int unsigned           CAPACITY    = 8,
  parameter int unsigned           MAX_TRIES   = 3,
  parameter int unsigned           PW_TIMEOUT  = 64,
  parameter int unsigned           LOCK_CYCLES = 16,
  localparam int unsigned          CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sensor_entrance,
  input  logic                sensor_exit,
  input  logic                car_depart,
  input  logic [PW_WIDTH-1:0] password,
  input  logic                pw_valid,
  output logic                GREEN_LED,
  output logic                RED_LED,
  output logic                gate_open,
  output logic                lot_full,
  output logic                locked_out,
  output logic [CNT_W-1:0]    occupancy,
  output logic [2:0]          state_o
);

  localparam int unsigned TMR_MAX = (PW_TIMEOUT > LOCK_CYCLES) ? PW_TIMEOUT : LOCK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0]   CAP_C     = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0]   PW_LAST   = TMR_W'(PW_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TRIES_W-1:0] TRIES_LIM = TRIES_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PW  = 3'd1,
    S_WRONG_PW = 3'd2,
    S_RIGHT_PW = 3'd3,
    S_STOP     = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  state_t             state_r, next_state_s;
  logic [TMR_W-1:0]   timer_r, timer_nx_s;
  logic [TRIES_W-1:0] tries_r, tries_nx_s;
  logic [CNT_W-1:0]   occupancy_r, occ_nx_s;
  logic               lot_full_r;
  logic               green_r, red_r, gate_r, locked_r;
  logic               green_nx_s, red_nx_s, gate_nx_s, locked_nx_s;
  logic               inc_s, dec_s;

  // Occupancy update: a simultaneous entry and departure cancel out.
  always_comb begin
    inc_s = (state_r == S_RIGHT_PW) && sensor_exit && (occupancy_r != CAP_C);
    dec_s = car_depart && (occupancy_r != {CNT_W{1'b0}});
    if (inc_s && !dec_s) begin
      occ_nx_s = occupancy_r + CNT_W'(1);
    end else if (dec_s && !inc_s) begin
      occ_nx_s = occupancy_r - CNT_W'(1);
    end else begin
      occ_nx_s = occupancy_r;
    end
  end

  // Next-state, retry counter and shared password/lockout timer.
  always_comb begin
    next_state_s = S_IDLE;
    tries_nx_s   = tries_r;
    timer_nx_s   = {TMR_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (sensor_entrance && !lot_full_r) begin
          next_state_s = S_WAIT_PW;
          tries_nx_s   = {TRIES_W{1'b0}};
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT_PW, S_WRONG_PW, S_STOP: begin
        if (pw_valid) begin
          if (password == PASSWORD) begin
            next_state_s = S_RIGHT_PW;
          end else if (tries_r + TRIES_W'(1) == TRIES_LIM) begin
            next_state_s = S_LOCKOUT;
            tries_nx_s   = tries_r + TRIES_W'(1);
          end else begin
            next_state_s = S_WRONG_PW;
            tries_nx_s   = tries_r + TRIES_W'(1);
          end
        end else if (timer_r == PW_LAST) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = state_r;
          timer_nx_s   = timer_r + TMR_W'(1);
        end
      end
      S_RIGHT_PW: begin
        if (sensor_exit) begin
          if (sensor_entrance && (occ_nx_s < CAP_C)) begin
            next_state_s = S_STOP;
            tries_nx_s   = {TRIES_W{1'b0}};
          end else begin
            next_state_s = S_IDLE;
          end
        end else begin
          next_state_s = S_RIGHT_PW;
        end
      end
      S_LOCKOUT: begin
        if (timer_r == LOCK_LAST) begin
          next_state_s = S_IDLE;
          tries_nx_s   = {TRIES_W{1'b0}};
        end else begin
          next_state_s = S_LOCKOUT;
          timer_nx_s   = timer_r + TMR_W'(1);
        end
      end
      default: begin
        next_state_s = S_IDLE;
        tries_nx_s   = {TRIES_W{1'b0}};
      end
    endcase
  end

  // Output values for the upcoming state, so the registered outputs line up with state_o.
  always_comb begin
    green_nx_s  = 1'b0;
    red_nx_s    = 1'b0;
    gate_nx_s   = 1'b0;
    locked_nx_s = 1'b0;
    case (next_state_s)
      S_IDLE:     red_nx_s = (state_r == S_IDLE) && sensor_entrance && lot_full_r;
      S_WAIT_PW:  red_nx_s = 1'b1;
      S_WRONG_PW, S_STOP: red_nx_s = (state_r != next_state_s) ? 1'b1 : ~red_r;
      S_RIGHT_PW: begin
        green_nx_s = 1'b1;
        gate_nx_s  = 1'b1;
      end
      S_LOCKOUT: begin
        red_nx_s    = 1'b1;
        locked_nx_s = 1'b1;
      end
      default: red_nx_s = 1'b0;
    endcase
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      timer_r     <= {TMR_W{1'b0}};
      tries_r     <= {TRIES_W{1'b0}};
      occupancy_r <= {CNT_W{1'b0}};
      lot_full_r  <= 1'b0;
      green_r     <= 1'b0;
      red_r       <= 1'b0;
      gate_r      <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      timer_r     <= timer_nx_s;
      tries_r     <= tries_nx_s;
      occupancy_r <= occ_nx_s;
      lot_full_r  <= (occ_nx_s == CAP_C);
      green_r     <= green_nx_s;
      red_r       <= red_nx_s;
      gate_r      <= gate_nx_s;
      locked_r    <= locked_nx_s;
    end
  end

  assign GREEN_LED  = green_r;
  assign RED_LED    = red_r;
  assign gate_open  = gate_r;
  assign lot_full   = lot_full_r;
  assign locked_out = locked_r;
  assign occupancy  = occupancy_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed per-cycle stimulus pushes the
// hand-computed expected output vector; an independent monitor pops and compares.
module tb_parking_gate_ctrl;

  logic       clk;
  logic       reset_n;
  logic       ent, ex, dep, pv;
  logic [3:0] pw;
  logic       green, red, gate, full, locked;
  logic [3:0] occ;
  logic [2:0] st;

  typedef struct {
    logic [11:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  parking_gate_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (ent),
    .sensor_exit     (ex),
    .car_depart      (dep),
    .password        (pw),
    .pw_valid        (pv),
    .GREEN_LED       (green),
    .RED_LED         (red),
    .gate_open       (gate),
    .lot_full        (full),
    .locked_out      (locked),
    .occupancy       (occ),
    .state_o         (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {state, green, red, gate, full, locked, occupancy}
  function automatic logic [11:0] E(input int s, input logic g, input logic r,
                                    input logic go, input logic f, input logic lk,
                                    input int o);
    return {3'(s), g, r, go, f, lk, 4'(o)};
  endfunction

  // Push the expectation for the coming edge, then advance; strobes last one cycle.
  task automatic step(input logic [11:0] v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    pv  = 1'b0;
    dep = 1'b0;
  endtask

  // Monitor: sample just after each rising edge and compare against the scoreboard.
  initial begin
    exp_t e;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {st, green, red, gate, full, locked, occ};
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: actual st=%0d g=%b r=%b gate=%b full=%b lock=%b occ=%0d, required st=%0d g=%b r=%b gate=%b full=%b lock=%b occ=%0d",
                   e.tag, act[11:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
                   e.v[11:9], e.v[8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:0]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    ent = 1'b0; ex = 1'b0; dep = 1'b0; pv = 1'b0; pw = 4'h0;
    @(negedge clk);

    // 1: reset held 5 cycles, then release
    for (int i = 0; i < 5; i++) step(E(0,0,0,0,0,0,0), "reset_hold");
    reset_n = 1'b1;
    step(E(0,0,0,0,0,0,0), "post_reset");

    // 2: correct password, car passes
    ent = 1'b1; step(E(1,0,1,0,0,0,0), "t2_wait");
    step(E(1,0,1,0,0,0,0), "t2_wait_hold");
    pv = 1'b1; pw = 4'hB; step(E(3,1,0,1,0,0,0), "t2_right");
    ent = 1'b0; step(E(3,1,0,1,0,0,0), "t2_right_hold");
    ex = 1'b1; step(E(0,0,0,0,0,0,1), "t2_exit");
    ex = 1'b0; step(E(0,0,0,0,0,0,1), "t2_idle");

    // 3: three wrong passwords, blinking red, lockout ignores the right code
    ent = 1'b1; step(E(1,0,1,0,0,0,1), "t3_wait");
    ent = 1'b0;
    pv = 1'b1; pw = 4'h3; step(E(2,0,1,0,0,0,1), "t3_wrong1");
    step(E(2,0,0,0,0,0,1), "t3_blink0");
    step(E(2,0,1,0,0,0,1), "t3_blink1");
    step(E(2,0,0,0,0,0,1), "t3_blink2");
    pv = 1'b1; pw = 4'h3; step(E(2,0,1,0,0,0,1), "t3_wrong2");
    pv = 1'b1; pw = 4'h3; step(E(5,0,1,0,0,1,1), "t3_lock");
    for (int i = 0; i < 15; i++) begin
      if (i == 4) begin pv = 1'b1; pw = 4'hB; end
      step(E(5,0,1,0,0,1,1), "t3_lock_hold");
    end
    step(E(0,0,0,0,0,0,1), "t3_unlock");

    // 4: fill the lot, refused entry shows red, departure frees a space
    for (int o = 1; o < 8; o++) begin
      ent = 1'b1; step(E(1,0,1,0,0,0,o), "t4_wait");
      pv = 1'b1; pw = 4'hB; step(E(3,1,0,1,0,0,o), "t4_right");
      ent = 1'b0; ex = 1'b1; step(E(0,0,0,0,(o == 7),0,o+1), "t4_exit");
      ex = 1'b0;
    end
    ent = 1'b1; step(E(0,0,1,0,1,0,8), "t4_full_red");
    step(E(0,0,1,0,1,0,8), "t4_full_red_hold");
    ent = 1'b0; step(E(0,0,0,0,1,0,8), "t4_full_idle");
    dep = 1'b1; step(E(0,0,0,0,0,0,7), "t4_depart");
    dep = 1'b1; step(E(0,0,0,0,0,0,6), "t4_depart2");

    // 5: back-to-back car goes to STOP; increment and departure cancel
    ent = 1'b1; step(E(1,0,1,0,0,0,6), "t5_wait");
    pv = 1'b1; pw = 4'hB; step(E(3,1,0,1,0,0,6), "t5_right");
    ex = 1'b1; step(E(4,0,1,0,0,0,7), "t5_stop");
    ex = 1'b0; step(E(4,0,0,0,0,0,7), "t5_stop_blink0");
    step(E(4,0,1,0,0,0,7), "t5_stop_blink1");
    ent = 1'b0;
    pv = 1'b1; pw = 4'hB; step(E(3,1,0,1,0,0,7), "t5_right2");
    ex = 1'b1; dep = 1'b1; step(E(0,0,0,0,0,0,7), "t5_inc_dec");
    ex = 1'b0; step(E(0,0,0,0,0,0,7), "t5_idle");
    // last space taken with another car waiting: lot full, back to IDLE
    ent = 1'b1; step(E(1,0,1,0,0,0,7), "t5_wait_last");
    pv = 1'b1; pw = 4'hB; step(E(3,1,0,1,0,0,7), "t5_right_last");
    ex = 1'b1; step(E(0,0,0,0,1,0,8), "t5_full_exit");
    ex = 1'b0; step(E(0,0,1,0,1,0,8), "t5_full_hold");
    ent = 1'b0; dep = 1'b1; step(E(0,0,0,0,0,0,7), "t5_depart");

    // 6: password timeout, then reset mid-RIGHT_PW clears occupancy
    ent = 1'b1; step(E(1,0,1,0,0,0,7), "t6_wait");
    ent = 1'b0;
    for (int i = 0; i < 63; i++) step(E(1,0,1,0,0,0,7), "t6_wait_hold");
    step(E(0,0,0,0,0,0,7), "t6_timeout");
    dep = 1'b1; step(E(0,0,0,0,0,0,6), "t6_dep6");
    dep = 1'b1; step(E(0,0,0,0,0,0,5), "t6_dep5");
    ent = 1'b1; step(E(1,0,1,0,0,0,5), "t6_wait5");
    pv = 1'b1; pw = 4'hB; step(E(3,1,0,1,0,0,5), "t6_right5");
    ent = 1'b0; reset_n = 1'b0; step(E(0,0,0,0,0,0,0), "t6_reset");
    reset_n = 1'b1; step(E(0,0,0,0,0,0,0), "t6_after_reset");
    dep = 1'b1; step(E(0,0,0,0,0,0,0), "t6_dep_at_zero");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending expectations, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
